// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path.
// Holds the ALU opcode values, the MIPS primary opcode and R-type funct
// codes, the datapath mux encodings (ALU A/B, PC source) and the
// instruction-class type produced by the decoder.
package mips_multicycle_ctrl_pkg;

    // ALU operation codes
    localparam logic [5:0] ALU_ADD = 6'd0;
    localparam logic [5:0] ALU_SUB = 6'd1;
    localparam logic [5:0] ALU_SHL = 6'd2;
    localparam logic [5:0] ALU_SHR = 6'd3;
    localparam logic [5:0] ALU_SRA = 6'd4;
    localparam logic [5:0] ALU_SLT = 6'd5;
    localparam logic [5:0] ALU_AND = 6'd6;
    localparam logic [5:0] ALU_XOR = 6'd7;
    localparam logic [5:0] ALU_NOR = 6'd8;
    localparam logic [5:0] ALU_OR  = 6'd9;

    // MIPS primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    // ALU A select
    localparam logic [1:0] SRC_A_PC = 2'd0;
    localparam logic [1:0] SRC_A_RS = 2'd1;
    localparam logic [1:0] SRC_A_RT = 2'd2;

    // ALU B select
    localparam logic [2:0] SRC_B_RT       = 3'd0;
    localparam logic [2:0] SRC_B_FOUR     = 3'd1;
    localparam logic [2:0] SRC_B_SEXT     = 3'd2;
    localparam logic [2:0] SRC_B_ZEXT     = 3'd3;
    localparam logic [2:0] SRC_B_SHAMT    = 3'd4;
    localparam logic [2:0] SRC_B_SEXT_SH2 = 3'd5;

    // PC next-value select
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // Instruction class resolved at decode
    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_BEQ = 3'd4,
        CLS_BNE = 3'd5,
        CLS_J   = 3'd6,
        CLS_BAD = 3'd7
    } instr_class_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] word);
        return word[5:0];
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction decoder for the multicycle control unit.
// Maps the primary opcode and R-type funct to an instruction class and to
// the ALU opcode / A select / B select used in the EXEC_R or EXEC_I state.
// Ports:
//   opcode      in  6  instr[31:26]
//   funct       in  6  instr[5:0]
//   iclass      out    instruction class (CLS_BAD for anything undecodable)
//   exec_alu_op out 6  ALU opcode for the execute state
//   exec_src_a  out 2  ALU A select for the execute state
//   exec_src_b  out 3  ALU B select for the execute state
module mips_ctrl_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_e iclass,
    output logic [5:0]   exec_alu_op,
    output logic [1:0]   exec_src_a,
    output logic [2:0]   exec_src_b
);

    // Opcode/funct lookup; unsupported encodings fall through to CLS_BAD
    always_comb begin
        iclass      = CLS_BAD;
        exec_alu_op = ALU_ADD;
        exec_src_a  = SRC_A_RS;
        exec_src_b  = SRC_B_RT;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: begin iclass = CLS_R; exec_alu_op = ALU_ADD; end
                    F_SUB, F_SUBU: begin iclass = CLS_R; exec_alu_op = ALU_SUB; end
                    F_AND:         begin iclass = CLS_R; exec_alu_op = ALU_AND; end
                    F_OR:          begin iclass = CLS_R; exec_alu_op = ALU_OR;  end
                    F_XOR:         begin iclass = CLS_R; exec_alu_op = ALU_XOR; end
                    F_NOR:         begin iclass = CLS_R; exec_alu_op = ALU_NOR; end
                    F_SLT:         begin iclass = CLS_R; exec_alu_op = ALU_SLT; end
                    // Shifts operate on rt by the shamt field
                    F_SLL: begin
                        iclass = CLS_R; exec_alu_op = ALU_SHL;
                        exec_src_a = SRC_A_RT; exec_src_b = SRC_B_SHAMT;
                    end
                    F_SRL: begin
                        iclass = CLS_R; exec_alu_op = ALU_SHR;
                        exec_src_a = SRC_A_RT; exec_src_b = SRC_B_SHAMT;
                    end
                    F_SRA: begin
                        iclass = CLS_R; exec_alu_op = ALU_SRA;
                        exec_src_a = SRC_A_RT; exec_src_b = SRC_B_SHAMT;
                    end
                    default: iclass = CLS_BAD;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                iclass = CLS_I; exec_alu_op = ALU_ADD; exec_src_b = SRC_B_SEXT;
            end
            OP_SLTI: begin
                iclass = CLS_I; exec_alu_op = ALU_SLT; exec_src_b = SRC_B_SEXT;
            end
            // Logical immediates are zero-extended
            OP_ANDI: begin
                iclass = CLS_I; exec_alu_op = ALU_AND; exec_src_b = SRC_B_ZEXT;
            end
            OP_ORI: begin
                iclass = CLS_I; exec_alu_op = ALU_OR; exec_src_b = SRC_B_ZEXT;
            end
            OP_XORI: begin
                iclass = CLS_I; exec_alu_op = ALU_XOR; exec_src_b = SRC_B_ZEXT;
            end
            OP_LW:   iclass = CLS_LW;
            OP_SW:   iclass = CLS_SW;
            OP_BEQ:  iclass = CLS_BEQ;
            OP_BNE:  iclass = CLS_BNE;
            OP_J:    iclass = CLS_J;
            default: iclass = CLS_BAD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit.
// Sequences FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK for each
// instruction and drives the ALU opcode, datapath mux selects and write
// strobes. Memory accesses use a req/ack handshake: the request is held
// until mem_ack is sampled high.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   instr   in  32    instruction register, valid from DECODE onward
//   zero    in  1     ALU zero flag (branch resolution)
//   mem_ack in  1     memory completed the request this cycle
//   alu_op  out OPW   ALU operation
//   alu_src_a/alu_src_b/pc_src   datapath mux selects
//   pc_write, ir_write, mem_req, mem_we, iord, reg_write, reg_dst,
//   mem_to_reg        datapath strobes/selects
//   illegal out 1     one-cycle pulse on an undecodable instruction
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [31:0]    instr,
    input  logic           zero,
    input  logic           mem_ack,
    output logic [OPW-1:0] alu_op,
    output logic [1:0]     alu_src_a,
    output logic [2:0]     alu_src_b,
    output logic [1:0]     pc_src,
    output logic           pc_write,
    output logic           ir_write,
    output logic           mem_req,
    output logic           mem_we,
    output logic           iord,
    output logic           reg_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_WB_R     = 4'd10,
        S_WB_I     = 4'd11
    } state_e;

    state_e       state_r;
    // Cleared by reset and set on the first clock edge after release, so
    // all outputs stay low during reset and the first request starts in
    // the cycle following that edge.
    logic         run_r;

    instr_class_e iclass_s;
    logic [5:0]   exec_alu_op_s;
    logic [1:0]   exec_src_a_s;
    logic [2:0]   exec_src_b_s;

    logic [5:0]   alu_op_s;
    logic [1:0]   alu_src_a_s;
    logic [2:0]   alu_src_b_s;
    logic [1:0]   pc_src_s;
    logic         pc_write_s;
    logic         ir_write_s;
    logic         mem_req_s;
    logic         mem_we_s;
    logic         iord_s;
    logic         reg_write_s;
    logic         reg_dst_s;
    logic         mem_to_reg_s;
    logic         illegal_s;

    // Register/immediate fields are consumed by the datapath, not here
    logic         unused_instr_fields_s;
    assign unused_instr_fields_s = ^instr[25:6];

    mips_ctrl_decode u_decode (
        .opcode      (opcode_of(instr)),
        .funct       (funct_of(instr)),
        .iclass      (iclass_s),
        .exec_alu_op (exec_alu_op_s),
        .exec_src_a  (exec_src_a_s),
        .exec_src_b  (exec_src_b_s)
    );

    // State sequencing; mem_ack only matters in the three request states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
            run_r   <= 1'b0;
        end else begin
            run_r <= 1'b1;
            case (state_r)
                S_FETCH: begin
                    if (run_r && mem_ack) state_r <= S_DECODE;
                    else                  state_r <= S_FETCH;
                end
                S_DECODE: begin
                    case (iclass_s)
                        CLS_R:           state_r <= S_EXEC_R;
                        CLS_I:           state_r <= S_EXEC_I;
                        CLS_LW, CLS_SW:  state_r <= S_MEM_ADDR;
                        CLS_BEQ, CLS_BNE: state_r <= S_BRANCH;
                        CLS_J:           state_r <= S_JUMP;
                        default:         state_r <= S_FETCH;
                    endcase
                end
                S_EXEC_R:   state_r <= S_WB_R;
                S_EXEC_I:   state_r <= S_WB_I;
                S_MEM_ADDR: state_r <= (iclass_s == CLS_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD: begin
                    if (mem_ack) state_r <= S_MEM_WB;
                    else         state_r <= S_MEM_RD;
                end
                S_MEM_WR: begin
                    if (mem_ack) state_r <= S_FETCH;
                    else         state_r <= S_MEM_WR;
                end
                S_MEM_WB, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: state_r <= S_FETCH;
                default:    state_r <= S_FETCH;
            endcase
        end
    end

    // Output decode from the state register and instr; FETCH's write
    // strobes follow mem_ack and BRANCH's pc_write follows zero
    always_comb begin
        alu_op_s     = ALU_ADD;
        alu_src_a_s  = SRC_A_PC;
        alu_src_b_s  = SRC_B_RT;
        pc_src_s     = PC_SRC_ALU;
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        iord_s       = 1'b0;
        reg_write_s  = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        illegal_s    = 1'b0;
        if (run_r) begin
            case (state_r)
                S_FETCH: begin
                    mem_req_s   = 1'b1;
                    alu_src_b_s = SRC_B_FOUR;
                    ir_write_s  = mem_ack;
                    pc_write_s  = mem_ack;
                end
                S_DECODE: begin
                    alu_src_b_s = SRC_B_SEXT_SH2;
                    illegal_s   = (iclass_s == CLS_BAD);
                end
                S_EXEC_R, S_EXEC_I: begin
                    alu_op_s    = exec_alu_op_s;
                    alu_src_a_s = exec_src_a_s;
                    alu_src_b_s = exec_src_b_s;
                end
                S_WB_R: begin
                    reg_write_s = 1'b1;
                    reg_dst_s   = 1'b1;
                end
                S_WB_I: begin
                    reg_write_s = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a_s = SRC_A_RS;
                    alu_src_b_s = SRC_B_SEXT;
                end
                S_MEM_RD: begin
                    mem_req_s = 1'b1;
                    iord_s    = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_s  = 1'b1;
                    mem_to_reg_s = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req_s = 1'b1;
                    mem_we_s  = 1'b1;
                    iord_s    = 1'b1;
                end
                S_BRANCH: begin
                    alu_op_s    = ALU_SUB;
                    alu_src_a_s = SRC_A_RS;
                    alu_src_b_s = SRC_B_RT;
                    pc_src_s    = PC_SRC_ALUOUT;
                    pc_write_s  = (iclass_s == CLS_BNE) ? ~zero : zero;
                end
                S_JUMP: begin
                    pc_write_s = 1'b1;
                    pc_src_s   = PC_SRC_JUMP;
                end
                default: begin
                    alu_op_s = ALU_ADD;
                end
            endcase
        end else begin
            alu_op_s = ALU_ADD;
        end
    end

    assign alu_op     = OPW'(alu_op_s);
    assign alu_src_a  = alu_src_a_s;
    assign alu_src_b  = alu_src_b_s;
    assign pc_src     = pc_src_s;
    assign pc_write   = pc_write_s;
    assign ir_write   = ir_write_s;
    assign mem_req    = mem_req_s;
    assign mem_we     = mem_we_s;
    assign iord       = iord_s;
    assign reg_write  = reg_write_s;
    assign reg_dst    = reg_dst_s;
    assign mem_to_reg = mem_to_reg_s;
    assign illegal    = illegal_s;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl.
// For each instruction a per-cycle plan (inputs to apply and outputs
// expected) is built from the instruction-level rules, then played into
// the DUT; a single negedge process compares every cycle.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic [5:0]  alu_op;
    logic [1:0]  alu_src_a;
    logic [2:0]  alu_src_b;
    logic [1:0]  pc_src;
    logic        pc_write, ir_write, mem_req, mem_we, iord;
    logic        reg_write, reg_dst, mem_to_reg, illegal;

    mips_multicycle_ctrl #(.OPW(6)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ack(mem_ack),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .pc_write(pc_write), .ir_write(ir_write),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] op;
        logic [1:0] sa;
        logic [2:0] sb;
        logic [1:0] ps;
        logic pcw, irw, mreq, mwe, iord, rw, rd, m2r, ill;
    } outs_t;

    typedef struct {
        logic [31:0] ins;
        logic        ack;
        logic        z;
        outs_t       e;
    } step_t;

    typedef struct {
        string nm;
        int    act;
        int    exp;
    } lit_t;

    step_t       plan[$];
    lit_t        lit_q[$];
    outs_t       exp_cur = '0;
    outs_t       act_s;
    bit          chk_on = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          step_idx = 0;
    int          force_z = -1;
    string       cur_name = "reset";
    logic [31:0] cur_ins;

    always_comb act_s = {alu_op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write,
                         mem_req, mem_we, iord, reg_write, reg_dst, mem_to_reg, illegal};

    // Single compare process: per-cycle DUT check plus queued model pins
    always @(negedge clk) begin
        while (lit_q.size() > 0) begin
            lit_t l;
            l = lit_q.pop_front();
            n_cmp++;
            if (l.act != l.exp) begin
                n_bad++;
                $display("FAIL %s: got %0d expected %0d", l.nm, l.act, l.exp);
            end
        end
        if (chk_on) begin
            n_cmp++;
            if (act_s !== exp_cur) begin
                n_bad++;
                $display("FAIL %s step %0d: got %h expected %h (instr %h)",
                         cur_name, step_idx, act_s, exp_cur, instr);
            end
        end
    end

    task automatic check_lit(input string nm, input int act, input int exp);
        lit_t l;
        l.nm = nm; l.act = act; l.exp = exp;
        lit_q.push_back(l);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic rz();
        if (force_z < 0) return 1'($urandom_range(0, 1));
        else             return force_z[0];
    endfunction

    // R-type funct -> ALU op, -1 when unsupported
    function automatic int r_alu(input logic [5:0] f);
        case (f)
            6'h20, 6'h21: return 0;
            6'h22, 6'h23: return 1;
            6'h24: return 6;
            6'h25: return 9;
            6'h26: return 7;
            6'h27: return 8;
            6'h2A: return 5;
            6'h00: return 2;
            6'h02: return 3;
            6'h03: return 4;
            default: return -1;
        endcase
    endfunction

    task automatic push(input logic a, input logic z, input outs_t o);
        step_t s;
        s.ins = cur_ins; s.ack = a; s.z = z; s.e = o;
        plan.push_back(s);
    endtask

    // Build the cycle plan of one instruction; fw/mw are memory wait
    // cycles for fetch and data access (-1 = random)
    task automatic build(input logic [31:0] ins, input int fw, input int mw);
        outs_t      o;
        logic       z;
        int         nf, nm, rop;
        logic [5:0] opc, fn;
        bit         bad;
        plan.delete();
        cur_ins = ins;
        opc = ins[31:26];
        fn  = ins[5:0];
        nf  = (fw < 0) ? int'($urandom_range(0, 2)) : fw;
        nm  = (mw < 0) ? int'($urandom_range(0, 3)) : mw;
        o = '0; o.mreq = 1'b1; o.sb = 3'd1;
        repeat (nf) push(1'b0, rz(), o);
        o.irw = 1'b1; o.pcw = 1'b1;
        push(1'b1, rz(), o);
        rop = r_alu(fn);
        case (opc)
            6'h00: bad = (rop < 0);
            6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
            6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        o = '0; o.sb = 3'd5; o.ill = bad;
        push(rbit(), rz(), o);
        if (!bad) begin
            o = '0;
            case (opc)
                6'h00: begin
                    o.op = 6'(rop);
                    o.sa = (fn < 6'h04) ? 2'd2 : 2'd1;
                    o.sb = (fn < 6'h04) ? 3'd4 : 3'd0;
                    push(rbit(), rz(), o);
                    o = '0; o.rw = 1'b1; o.rd = 1'b1;
                    push(rbit(), rz(), o);
                end
                6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
                    o.sa = 2'd1;
                    o.sb = (opc >= 6'h0C) ? 3'd3 : 3'd2;
                    o.op = (opc == 6'h0A) ? 6'd5 : (opc == 6'h0C) ? 6'd6 :
                           (opc == 6'h0D) ? 6'd9 : (opc == 6'h0E) ? 6'd7 : 6'd0;
                    push(rbit(), rz(), o);
                    o = '0; o.rw = 1'b1;
                    push(rbit(), rz(), o);
                end
                6'h23, 6'h2B: begin
                    o.sa = 2'd1; o.sb = 3'd2;
                    push(rbit(), rz(), o);
                    o = '0; o.mreq = 1'b1; o.iord = 1'b1; o.mwe = (opc == 6'h2B);
                    repeat (nm) push(1'b0, rz(), o);
                    push(1'b1, rz(), o);
                    if (opc == 6'h23) begin
                        o = '0; o.rw = 1'b1; o.m2r = 1'b1;
                        push(rbit(), rz(), o);
                    end
                end
                6'h04, 6'h05: begin
                    z = rz();
                    o.op = 6'd1; o.sa = 2'd1; o.sb = 3'd0; o.ps = 2'd1;
                    o.pcw = (opc == 6'h04) ? z : ~z;
                    push(rbit(), z, o);
                end
                6'h02: begin
                    o.pcw = 1'b1; o.ps = 2'd2;
                    push(rbit(), rz(), o);
                end
                default: o = '0;
            endcase
        end
    endtask

    // Play the first n steps of the plan (n < 0: all of it)
    task automatic play(input int n);
        int lim;
        lim = (n < 0 || n > plan.size()) ? plan.size() : n;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            #1;
            instr    = plan[i].ins;
            mem_ack  = plan[i].ack;
            zero     = plan[i].z;
            exp_cur  = plan[i].e;
            step_idx = i;
            chk_on   = 1'b1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  opc;
        w = $urandom;
        case ($urandom_range(0, 15))
            0, 1, 2: opc = 6'h00;
            3:  opc = 6'h08;
            4:  opc = 6'h09;
            5:  opc = 6'h0A;
            6:  opc = 6'h0C;
            7:  opc = 6'h0D;
            8:  opc = 6'h0E;
            9:  opc = 6'h23;
            10: opc = 6'h2B;
            11: opc = 6'h04;
            12: opc = 6'h05;
            13: opc = 6'h02;
            14: opc = 6'($urandom);
            default: opc = 6'h3F;
        endcase
        w[31:26] = opc;
        if (opc == 6'h00) begin
            case ($urandom_range(0, 13))
                0:  w[5:0] = 6'h20;
                1:  w[5:0] = 6'h21;
                2:  w[5:0] = 6'h22;
                3:  w[5:0] = 6'h23;
                4:  w[5:0] = 6'h24;
                5:  w[5:0] = 6'h25;
                6:  w[5:0] = 6'h26;
                7:  w[5:0] = 6'h27;
                8:  w[5:0] = 6'h2A;
                9:  w[5:0] = 6'h00;
                10: w[5:0] = 6'h02;
                11: w[5:0] = 6'h03;
                12: w[5:0] = 6'h01;
                default: w[5:0] = 6'($urandom);
            endcase
        end
        return w;
    endfunction

    function automatic int count_mem_rd();
        int c;
        c = 0;
        foreach (plan[i]) if (plan[i].e.mreq && plan[i].e.iord) c++;
        return c;
    endfunction

    initial begin
        // Reset: outputs must be zero, even with mem_ack toggling
        exp_cur = '0;
        chk_on  = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            mem_ack = rbit();
            instr   = $urandom;
        end
        // Release between edges; nothing is requested before the next edge
        @(posedge clk);
        #3;
        rst_n   = 1'b1;
        mem_ack = 1'b0;

        cur_name = "add";
        build(32'h00221820, 0, 0);
        check_lit("add_cycles", plan.size(), 4);
        check_lit("add_exec_op", plan[2].e.op, 0);
        check_lit("add_exec_sa", plan[2].e.sa, 1);
        check_lit("add_exec_sb", plan[2].e.sb, 0);
        check_lit("add_wb", {plan[3].e.rw, plan[3].e.rd}, 3);
        play(-1);

        cur_name = "sll";
        build(32'h00011100, -1, -1);
        check_lit("sll_exec", {plan[plan.size()-2].e.op, plan[plan.size()-2].e.sa,
                               plan[plan.size()-2].e.sb}, {6'd2, 2'd2, 3'd4});
        play(-1);

        cur_name = "lw_wait3";
        build(32'h8C220004, 0, 3);
        check_lit("lw_cycles", plan.size(), 8);
        check_lit("lw_req_hold", count_mem_rd(), 4);
        check_lit("lw_m2r", plan[7].e.m2r, 1);
        play(-1);

        cur_name = "sw";
        build(32'hAC220008, 0, 0);
        check_lit("sw_cycles", plan.size(), 4);
        play(-1);

        for (int k = 0; k < 4; k++) begin
            force_z  = k % 2;
            cur_name = (k < 2) ? "beq" : "bne";
            build((k < 2) ? 32'h10220003 : 32'h14220003, 0, 0);
            check_lit("br_cycles", plan.size(), 3);
            check_lit("br_pc_src", plan[2].e.ps, 1);
            check_lit("br_pc_write", plan[2].e.pcw, (k == 1 || k == 2) ? 1 : 0);
            play(-1);
        end
        force_z = -1;

        cur_name = "j";
        build(32'h08000010, 0, 0);
        check_lit("j_cycles", plan.size(), 3);
        play(-1);

        cur_name = "illegal";
        build(32'hFC000000, 0, 0);
        check_lit("ill_cycles", plan.size(), 2);
        check_lit("ill_pulse", plan[1].e.ill, 1);
        check_lit("ill_nowrite", {plan[1].e.rw, plan[1].e.pcw, plan[1].e.mwe}, 0);
        play(-1);

        cur_name = "random";
        repeat (200) begin
            build(rand_instr(), -1, -1);
            play(-1);
        end

        // Reset in MEM_WR: outputs drop at once, fresh FETCH afterwards
        cur_name = "sw_abort";
        build(32'hAC220008, 0, 5);
        play(4);
        @(posedge clk);
        #1;
        cur_name = "rst_abort";
        rst_n    = 1'b0;
        mem_ack  = 1'b1;
        exp_cur  = '0;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        #2;
        rst_n = 1'b1;

        cur_name = "after_rst";
        build(32'h00221820, 1, 0);
        play(-1);

        cur_name = "random2";
        repeat (50) begin
            build(rand_instr(), -1, -1);
            play(-1);
        end

        @(negedge clk);
        #1;
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
